// File: rtl/plat_pkg.sv
// plat_pkg: platform field constants, FSM states and initial slot positions
package plat_pkg;
    localparam int N_PLAT = 16;
    localparam int SCREEN_H = 480;
    localparam int SCROLL_LINE = 160;
    localparam int MAX_SCROLL = 8;
    localparam int X_MIN = 10;
    typedef enum logic [1:0] {IDLE, CALC, UPDATE, DONE} plat_state_t;
    function automatic logic [9:0] init_x(input int i);
        return 10'(64 + 32 * i);
    endfunction
    function automatic logic [9:0] init_y(input int i);
        return 10'(30 * i + 15);
    endfunction
endpackage

// File: rtl/plat_lfsr.sv
// plat_lfsr: 10-bit Fibonacci LFSR x^10+x^7+1, seed 10'h1FF, stepping every Clk
module plat_lfsr (
    input  logic       Clk,
    input  logic       Reset,
    output logic [9:0] q
);
    always_ff @(posedge Clk) q <= Reset ? 10'h1FF : {q[8:0], q[9] ^ q[6]};
endmodule

// File: rtl/platform_field.sv
// platform_field: per-frame scroll of 16 platforms with wrap-around respawn and double-buffered display buses
module platform_field
    import plat_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic [9:0]           BallY,
    output logic [N_PLAT*10-1:0] platX_flat,
    output logic [N_PLAT*10-1:0] platY_flat,
    output logic                 scroll_valid,
    output logic [9:0]           scroll_amt,
    output logic                 busy,
    output logic [15:0]          respawn_count
);
    plat_state_t state, state_n;
    logic fc_cur, fc_prev, fedge, wrap;
    logic [3:0] idx;
    logic [9:0] scroll, amt_q, diff, ny, r, rx;
    logic [9:0] wx [N_PLAT];
    logic [9:0] wy [N_PLAT];
    logic [9:0] dx [N_PLAT];
    logic [9:0] dy [N_PLAT];

    plat_lfsr u_lfsr (.Clk(Clk), .Reset(Reset), .q(r));

    assign fedge = fc_cur & ~fc_prev;
    assign diff = 10'(SCROLL_LINE) - BallY;
    assign ny = wy[idx] + scroll;
    assign wrap = ny >= 10'(SCREEN_H);
    assign rx = 10'(X_MIN) + (r >= 10'd620 ? r - 10'd512 : r);
    assign busy = state == CALC || state == UPDATE;
    assign scroll_valid = state == DONE;
    assign scroll_amt = scroll_valid ? scroll : amt_q;

    always_comb begin
        state_n = state == IDLE   ? (fedge ? CALC : IDLE) :
                  state == CALC   ? UPDATE :
                  state == UPDATE ? (idx == 4'(N_PLAT - 1) ? DONE : UPDATE) : IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            fc_cur <= 1'b0;
            fc_prev <= 1'b0;
            idx <= '0;
            scroll <= '0;
            amt_q <= '0;
            respawn_count <= '0;
            for (int i = 0; i < N_PLAT; i++) begin
                wx[i] <= init_x(i);
                wy[i] <= init_y(i);
                dx[i] <= init_x(i);
                dy[i] <= init_y(i);
            end
        end else begin
            state <= state_n;
            fc_cur <= frame_clk;
            fc_prev <= fc_cur;
            if (state == CALC) begin
                scroll <= BallY < 10'(SCROLL_LINE) ? (diff > 10'(MAX_SCROLL) ? 10'(MAX_SCROLL) : diff) : '0;
                idx <= '0;
            end
            if (state == UPDATE) begin
                idx <= idx + 4'd1;
                wy[idx] <= wrap ? ny - 10'(SCREEN_H) : ny;
                if (wrap) begin
                    wx[idx] <= rx;
                    if (respawn_count != 16'hFFFF) respawn_count <= respawn_count + 16'd1;
                end
            end
            if (state == DONE) begin
                dx <= wx;
                dy <= wy;
                amt_q <= scroll;
            end
        end
    end

    for (genvar g = 0; g < N_PLAT; g++) begin : g_flat
        assign platX_flat[10*g +: 10] = dx[g];
        assign platY_flat[10*g +: 10] = dy[g];
    end
endmodule

// File: tb/tb_platform_field.sv
// tb_platform_field: timeline model of the platform field checked every cycle plus hand-computed expectations
module tb_platform_field;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic frame_clk = 1'b0;
    logic [9:0] BallY = 10'd200;
    logic [159:0] platX_flat, platY_flat;
    logic scroll_valid, busy;
    logic [9:0] scroll_amt;
    logic [15:0] respawn_count;

    int errors = 0;
    int checks = 0;

    platform_field dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .BallY(BallY),
        .platX_flat(platX_flat), .platY_flat(platY_flat), .scroll_valid(scroll_valid),
        .scroll_amt(scroll_amt), .busy(busy), .respawn_count(respawn_count)
    );

    always #5 Clk = ~Clk;

    int wx[16], wy[16], dx[16], dy[16];
    int cyc, ft, m_scroll, m_amt, m_cnt, k, ny;
    bit active, fcur, fprev;
    logic [9:0] lfsr, lfsr_prev;

    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                wx[i] = 64 + 32 * i;
                wy[i] = 30 * i + 15;
                dx[i] = wx[i];
                dy[i] = wy[i];
            end
            lfsr = 10'h1FF;
            cyc = 0;
            active = 0;
            fcur = 0;
            fprev = 0;
            m_scroll = 0;
            m_amt = 0;
            m_cnt = 0;
        end else begin
            lfsr_prev = lfsr;
            lfsr = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            cyc++;
            if (active && cyc == ft + 2)
                m_scroll = BallY < 160 ? ((160 - int'(BallY)) < 8 ? 160 - int'(BallY) : 8) : 0;
            if (active && cyc >= ft + 3 && cyc <= ft + 18) begin
                k = cyc - ft - 3;
                ny = wy[k] + m_scroll;
                if (ny >= 480) begin
                    wy[k] = ny - 480;
                    wx[k] = 10 + (lfsr_prev >= 620 ? int'(lfsr_prev) - 512 : int'(lfsr_prev));
                    if (m_cnt < 65535) m_cnt++;
                end else wy[k] = ny;
            end
            if (active && cyc == ft + 19) begin
                dx = wx;
                dy = wy;
                m_amt = m_scroll;
            end
            fprev = fcur;
            fcur = frame_clk;
            if (fcur && !fprev && (!active || cyc >= ft + 19)) begin
                active = 1;
                ft = cyc;
            end
        end
    end

    function automatic logic [159:0] flat(input int a[16]);
        logic [159:0] f;
        for (int i = 0; i < 16; i++) f[10*i +: 10] = 10'(a[i]);
        return f;
    endfunction

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit mv;
        @(negedge Clk);
        mv = active && cyc == ft + 18;
        chk("platX", platX_flat, flat(dx));
        chk("platY", platY_flat, flat(dy));
        chk("busy", 160'(busy), 160'(active && cyc >= ft + 1 && cyc <= ft + 17));
        chk("scroll_valid", 160'(scroll_valid), 160'(mv));
        chk("scroll_amt", 160'(scroll_amt), 160'(mv ? m_scroll : m_amt));
        chk("respawn_count", 160'(respawn_count), 160'(m_cnt));
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        step();
    endtask

    task automatic run_frame(input logic [9:0] by, input int amt);
        int n;
        BallY = by;
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        n = 0;
        while (!scroll_valid && n < 40) begin
            step();
            n++;
        end
        chk("valid_latency", 160'(n), 160'(18));
        chk("lit_amt", 160'(scroll_amt), 160'(amt));
        step();
    endtask

    initial begin
        int pulses;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        step();
        chk("lit_s0x", 160'(platX_flat[9:0]), 160'(64));
        chk("lit_s0y", 160'(platY_flat[9:0]), 160'(15));
        chk("lit_s15x", 160'(platX_flat[159:150]), 160'(544));
        chk("lit_s15y", 160'(platY_flat[159:150]), 160'(465));
        chk("lit_busy", 160'(busy), 160'(0));
        chk("lit_cnt", 160'(respawn_count), 160'(0));

        run_frame(10'd200, 0);
        chk("lit_noscroll_s0y", 160'(platY_flat[9:0]), 160'(15));
        chk("lit_noscroll_s15y", 160'(platY_flat[159:150]), 160'(465));

        run_frame(10'd100, 8);
        chk("lit_cap_s0y", 160'(platY_flat[9:0]), 160'(23));
        chk("lit_cap_s15y", 160'(platY_flat[159:150]), 160'(473));

        do_reset();
        run_frame(10'd155, 5);
        chk("lit_f1_s15y", 160'(platY_flat[159:150]), 160'(470));
        run_frame(10'd155, 5);
        chk("lit_f2_s15y", 160'(platY_flat[159:150]), 160'(475));
        run_frame(10'd155, 5);
        chk("lit_f3_s15y", 160'(platY_flat[159:150]), 160'(0));
        chk("lit_wrap_xrange", 160'(platX_flat[159:150] >= 11 && platX_flat[159:150] <= 629), 160'(1));
        chk("lit_wrap_cnt", 160'(respawn_count), 160'(1));
        chk("lit_s14y", 160'(platY_flat[149:140]), 160'(450));
        chk("lit_s14x", 160'(platX_flat[149:140]), 160'(512));

        do_reset();
        BallY = 10'd100;
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        pulses = 0;
        repeat (4) begin
            step();
            pulses += int'(scroll_valid);
        end
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        chk("lit_busy_drop", 160'(busy), 160'(1));
        repeat (40) begin
            step();
            pulses += int'(scroll_valid);
        end
        chk("lit_drop_pulses", 160'(pulses), 160'(1));
        chk("lit_drop_s0y", 160'(platY_flat[9:0]), 160'(23));
        chk("lit_drop_s15y", 160'(platY_flat[159:150]), 160'(473));

        do_reset();
        BallY = 10'd100;
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        repeat (7) step();
        chk("lit_mid_busy", 160'(busy), 160'(1));
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("lit_rst_busy", 160'(busy), 160'(0));
        chk("lit_rst_s0y", 160'(platY_flat[9:0]), 160'(15));
        pulses = 0;
        repeat (25) begin
            step();
            pulses += int'(scroll_valid);
        end
        chk("lit_rst_pulses", 160'(pulses), 160'(0));
        run_frame(10'd200, 0);
        chk("lit_discard_s0y", 160'(platY_flat[9:0]), 160'(15));
        chk("lit_discard_s15y", 160'(platY_flat[159:150]), 160'(465));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
